// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM state type.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_DATA,
        ST_WR,
        RMW_RD,
        RMW_WR,
        ERR
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract/extend and sub-word store merge
// into a little-endian memory word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic                  load_unsigned,
    input  logic [1:0]            byte_off,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_data
);

    logic [4:0]            bit_shift;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] lane_mask;

    assign bit_shift = {byte_off, 3'b000};

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        lane_b    = rdata[bit_shift +: 8];
        lane_h    = rdata[{byte_off[1], 4'b0000} +: 16];
        load_data = rdata;
        lane_mask = '1;
        case (size)
            SIZE_B: begin
                load_data = load_unsigned ? {{(DATA_WIDTH-8){1'b0}}, lane_b}
                                          : {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
                lane_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << bit_shift;
            end
            SIZE_H: begin
                load_data = load_unsigned ? {{(DATA_WIDTH-16){1'b0}}, lane_h}
                                          : {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
                lane_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << bit_shift;
            end
            default: ;
        endcase
        // Untouched lanes keep the word just read; selected lanes take the low store bits.
        store_data = (rdata & ~lane_mask) | ((wdata << bit_shift) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and a word-wide data memory
// with registered reads; sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  Mem_R_En,
    output logic                  Mem_W_En,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] readData
);

    lsu_state_e            state_q, state_d;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  accept;
    logic                  req_bad;
    logic [29:0]           req_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_data;

    assign accept   = req_valid && (state_q == IDLE);
    assign req_word = req_addr[31:2];

    always_comb begin
        req_bad = 1'b0;
        if (req_size == SIZE_X)                           req_bad = 1'b1;
        if (req_size == SIZE_H && req_addr[0])            req_bad = 1'b1;
        if (req_size == SIZE_W && req_addr[1:0] != 2'b00) req_bad = 1'b1;
        if (req_addr[31:ADDR_WIDTH+2] != '0)              req_bad = 1'b1;
        if (req_word >= 30'(MEM_SIZE))                    req_bad = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr[ADDR_WIDTH+1:0];
                wdata_q    <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad)              state_d = ERR;
                    else if (!req_write)      state_d = LD_RD;
                    else if (req_size == SIZE_W) state_d = ST_WR;
                    else                      state_d = RMW_RD;
                end
            end
            LD_RD:   state_d = LD_DATA;
            RMW_RD:  state_d = RMW_WR;
            default: state_d = IDLE;
        endcase
    end

    lsu_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .size          (size_q),
        .load_unsigned (unsigned_q),
        .byte_off      (addr_q[1:0]),
        .rdata         (readData),
        .wdata         (wdata_q),
        .load_data     (load_data),
        .store_data    (store_data)
    );

    // All outputs decode from the registered state, so reset clears them without waiting for a clock.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        Mem_R_En   = 1'b0;
        Mem_W_En   = 1'b0;
        address    = '0;
        writeData  = '0;
        case (state_q)
            LD_RD, RMW_RD: begin
                Mem_R_En = 1'b1;
                address  = addr_q[ADDR_WIDTH+1:2];
            end
            LD_DATA: begin
                resp_valid = 1'b1;
                resp_rdata = load_data;
            end
            ST_WR: begin
                Mem_W_En   = 1'b1;
                address    = addr_q[ADDR_WIDTH+1:2];
                writeData  = wdata_q;
                resp_valid = 1'b1;
            end
            RMW_WR: begin
                Mem_W_En   = 1'b1;
                address    = addr_q[ADDR_WIDTH+1:2];
                writeData  = store_data;
                resp_valid = 1'b1;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random accesses
// compared against a byte-addressed reference memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MS = 1024;

    logic          clk;
    logic          nReset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          Mem_R_En;
    logic          Mem_W_En;
    logic [AW-1:0] address;
    logic [DW-1:0] writeData;
    logic [DW-1:0] readData;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .nReset(nReset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .Mem_R_En(Mem_R_En), .Mem_W_En(Mem_W_En),
        .address(address), .writeData(writeData), .readData(readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h0102_0304;
    endfunction

    // External data memory: registered read, synchronous write.
    logic [DW-1:0] mem [MS];
    logic          preload;
    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MS; i++) mem[i] <= init_word(i);
            readData <= '0;
        end else begin
            if (Mem_R_En) readData <= mem[address];
            if (Mem_W_En) mem[address] <= writeData;
        end
    end

    // Reference model: plain byte array, little-endian.
    logic [7:0] ref_bytes [MS*4];

    function automatic logic model_err(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
               || ((a >> 2) >= 32'(MS));
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] sz, logic uns, logic [31:0] a);
        int n = 1 << sz;
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v |= 32'(ref_bytes[int'(a) + i]) << (8 * i);
        if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    task automatic model_store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_bytes[int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ctl"}, {59'd0, req_ready, resp_valid, resp_err, Mem_R_En, Mem_W_En}, 64'b10000);
        check({tag, " rdata"}, 64'(resp_rdata), 64'd0);
        check({tag, " address"}, 64'(address), 64'd0);
        check({tag, " writeData"}, 64'(writeData), 64'd0);
    endtask

    // One complete request: drive, observe up to four cycles, compare with the model.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rdata_o);
        logic          exp_err;
        logic [31:0]   exp_rdata, exp_word, got_rdata, got_wdata;
        logic [AW-1:0] got_raddr, got_waddr;
        logic          got_err;
        int            exp_resp, exp_r, exp_w, resp_at, r_at, w_at, n_resp, n_both;
        exp_err = model_err(sz, a);
        exp_rdata = 0; exp_word = 0; got_rdata = 0; got_wdata = 0; got_err = 0;
        got_raddr = 0; got_waddr = 0;
        resp_at = -1; r_at = -1; w_at = -1; n_resp = 0; n_both = 0;

        @(negedge clk);
        check({tag, " ready"}, 64'(req_ready), 64'd1);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                n_resp++;
                if (resp_at < 0) begin
                    resp_at = k; got_err = resp_err; got_rdata = resp_rdata;
                end
            end
            if (Mem_R_En && r_at < 0) begin r_at = k; got_raddr = address; end
            if (Mem_W_En && w_at < 0) begin w_at = k; got_waddr = address; got_wdata = writeData; end
            if (Mem_R_En && Mem_W_En) n_both++;
        end

        if (exp_err) begin
            exp_resp = 1; exp_r = -1; exp_w = -1;
        end else if (!wr) begin
            exp_resp = 2; exp_r = 1; exp_w = -1;
            exp_rdata = model_load(sz, uns, a);
        end else begin
            model_store(sz, a, wd);
            exp_word = model_load(2'd2, 1'b1, {a[31:2], 2'b00});
            exp_resp = (sz == 2'd2) ? 1 : 2;
            exp_r    = (sz == 2'd2) ? -1 : 1;
            exp_w    = exp_resp;
        end

        check({tag, " resp cycle"}, 64'(resp_at), 64'(exp_resp));
        check({tag, " resp count"}, 64'(n_resp), 64'd1);
        check({tag, " resp_err"}, 64'(got_err), 64'(exp_err));
        check({tag, " resp_rdata"}, 64'(got_rdata), 64'(exp_rdata));
        check({tag, " read cycle"}, 64'(r_at), 64'(exp_r));
        check({tag, " write cycle"}, 64'(w_at), 64'(exp_w));
        check({tag, " strobe overlap"}, 64'(n_both), 64'd0);
        if (exp_r > 0) check({tag, " read addr"}, 64'(got_raddr), 64'(a[AW+1:2]));
        if (exp_w > 0) begin
            check({tag, " write addr"}, 64'(got_waddr), 64'(a[AW+1:2]));
            check({tag, " writeData"}, 64'(got_wdata), 64'(exp_word));
        end
        rdata_o = got_rdata;
    endtask

    initial begin
        logic [31:0] rd, w;
        logic [10:0] resp_mask, rd_mask;
        logic        seen;
        int          r;
        logic [1:0]  sz;
        logic [31:0] a;

        for (int i = 0; i < MS; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = w[8*b +: 8];
        end
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        preload = 1'b1;
        nReset  = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        nReset  = 1'b1;
        @(negedge clk);
        check_idle_outputs("post-reset idle");

        // Word store / load round trip, then byte RMW over it.
        do_req("st_w 0x010", 1, SIZE_W, 0, 32'h010, 32'hDEAD_BEEF, rd);
        do_req("ld_w 0x010", 0, SIZE_W, 0, 32'h010, 0, rd);
        check("ld_w 0x010 const", 64'(rd), 64'hDEAD_BEEF);
        do_req("st_b 0x012", 1, SIZE_B, 0, 32'h012, 32'h0000_0055, rd);
        do_req("ld_w after rmw", 0, SIZE_W, 0, 32'h010, 0, rd);
        check("rmw word const", 64'(rd), 64'hDE55_BEEF);
        do_req("ld_b s 0x013", 0, SIZE_B, 0, 32'h013, 0, rd);
        check("ld_b s const", 64'(rd), 64'hFFFF_FFDE);
        do_req("ld_b u 0x013", 0, SIZE_B, 1, 32'h013, 0, rd);
        check("ld_b u const", 64'(rd), 64'h0000_00DE);
        do_req("ld_h s 0x010", 0, SIZE_H, 0, 32'h010, 0, rd);
        check("ld_h s const", 64'(rd), 64'hFFFF_BEEF);

        // Rejected accesses.
        do_req("err misaligned word", 0, SIZE_W, 0, 32'h011, 0, rd);
        do_req("err misaligned half", 0, SIZE_H, 0, 32'h013, 0, rd);
        do_req("err size3", 0, SIZE_X, 0, 32'h010, 0, rd);
        do_req("err range", 0, SIZE_W, 0, 32'h1000, 0, rd);
        do_req("err range store", 1, SIZE_B, 0, 32'h8000_0010, 32'h77, rd);
        do_req("ld_w after err store", 0, SIZE_W, 0, 32'h010, 0, rd);
        do_req("st_h last word", 1, SIZE_H, 0, 32'hFFE, 32'h1234_ABCD, rd);
        do_req("ld_w last word", 0, SIZE_W, 0, 32'hFFC, 0, rd);

        // req_valid held high across three loads.
        @(negedge clk);
        req_write = 0; req_size = SIZE_W; req_unsigned = 0; req_addr = 32'h010; req_valid = 1'b1;
        resp_mask = '0; rd_mask = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                resp_mask[n] = 1'b1;
                check("held-valid rdata", 64'(resp_rdata), 64'(model_load(SIZE_W, 0, 32'h010)));
            end
            if (Mem_R_En) rd_mask[n] = 1'b1;
            if (n == 8) req_valid = 1'b0;
        end
        check("held-valid resp cycles", 64'(resp_mask), 64'(11'b001_0010_0100));
        check("held-valid read cycles", 64'(rd_mask), 64'(11'b000_1001_0010));

        // Reset during the read phase of a byte store.
        @(negedge clk);
        req_write = 1; req_size = SIZE_B; req_unsigned = 0; req_addr = 32'h021; req_wdata = 32'hA5;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw read phase", 64'(Mem_R_En), 64'd1);
        nReset = 1'b0;
        #1 check_idle_outputs("mid-rmw reset");
        @(posedge clk);
        @(negedge clk);
        nReset = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= resp_valid | Mem_W_En | Mem_R_En;
        end
        check("quiet after reset", 64'(seen), 64'd0);
        do_req("ld_w after abandoned rmw", 0, SIZE_W, 0, 32'h020, 0, rd);

        // Random traffic over a small window, with occasional illegal requests.
        for (int t = 0; t < 80; t++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = 32'h40 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | 32'h0000_1000;
            do_req("random", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
